// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with a memory-ready wait counter and timeout watchdog.
// Optional jump support is compiled in when MC_JUMP_EN is defined.
module mips_mc_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       beq,
    output logic       bne,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] dbg_state
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] MEM_ADDR = 4'd3;
    localparam logic [3:0] MEM_RD   = 4'd4;
    localparam logic [3:0] MEM_WB   = 4'd5;
    localparam logic [3:0] MEM_WR   = 4'd6;
    localparam logic [3:0] EXEC     = 4'd7;
    localparam logic [3:0] ALU_WB   = 4'd8;
    localparam logic [3:0] ADDI_EX  = 4'd9;
    localparam logic [3:0] ADDI_WB  = 4'd10;
    localparam logic [3:0] BRANCH   = 4'd11;
`ifdef MC_JUMP_EN
    localparam logic [3:0] JUMP     = 4'd12;
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // cnt holds the number of cycles already waited; the current cycle is the last allowed one
    // when cnt equals MEM_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign dbg_state = state;

    always_comb begin
        state_next = state;
        cnt_next   = 8'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        case (state)
            IDLE: state_next = FETCH;

            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (cnt == TIMEOUT_LAST) begin
                    // Re-entering FETCH clears the counter and refetches the same PC.
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_next = EXEC;
                    OP_LW, OP_SW:  state_next = MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI:       state_next = ADDI_EX;
`ifdef MC_JUMP_EN
                    OP_J:          state_next = JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end

            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end

            MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = MEM_WB;
                end else if (cnt == TIMEOUT_LAST) begin
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end

            MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end else if (cnt == TIMEOUT_LAST) begin
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end

            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = ALU_WB;
            end

            ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end

            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDI_WB;
            end

            ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end

            BRANCH: begin
                // The branch unit owns the PC update here; pc_write stays low.
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                beq        = (opcode == OP_BEQ);
                bne        = (opcode == OP_BNE);
                state_next = FETCH;
            end

`ifdef MC_JUMP_EN
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                state_next = FETCH;
            end
`endif

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: a per-instruction cycle model builds expected output vectors,
// which are compared against the DUT sampled mid-cycle.
module tb_mips_mc_control;

    localparam int T = 15;

    // Output vector bit masks (bit layout of the packed outs below).
    localparam logic [18:0] M_IORD      = 19'h1 << 18;
    localparam logic [18:0] M_MEM_READ  = 19'h1 << 17;
    localparam logic [18:0] M_MEM_WRITE = 19'h1 << 16;
    localparam logic [18:0] M_IR_WRITE  = 19'h1 << 15;
    localparam logic [18:0] M_REG_DST   = 19'h1 << 14;
    localparam logic [18:0] M_MEM_TO_RG = 19'h1 << 13;
    localparam logic [18:0] M_REG_WRITE = 19'h1 << 12;
    localparam logic [18:0] M_SRC_A     = 19'h1 << 11;
    localparam logic [18:0] M_SRCB_4    = 19'h1 << 9;
    localparam logic [18:0] M_SRCB_IMM  = 19'h2 << 9;
    localparam logic [18:0] M_SRCB_SH   = 19'h3 << 9;
    localparam logic [18:0] M_OP_SUB    = 19'h1 << 7;
    localparam logic [18:0] M_OP_FUNCT  = 19'h2 << 7;
    localparam logic [18:0] M_PC_ALUOUT = 19'h1 << 5;
    localparam logic [18:0] M_PC_JUMP   = 19'h2 << 5;
    localparam logic [18:0] M_PC_WRITE  = 19'h1 << 4;
    localparam logic [18:0] M_BEQ       = 19'h1 << 3;
    localparam logic [18:0] M_BNE       = 19'h1 << 2;
    localparam logic [18:0] M_ILLEGAL   = 19'h1 << 1;
    localparam logic [18:0] M_MEM_ERR   = 19'h1;

`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_write, beq, bne, illegal_op, mem_err;
    logic [3:0] dbg_state;
    logic [18:0] outs;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q[$];
    logic [18:0] got_q[$];
    logic        rdy_q[$];
    logic [5:0]  op_q[$];

    mips_mc_control #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_write(pc_write), .beq(beq), .bne(bne), .illegal_op(illegal_op),
        .mem_err(mem_err), .dbg_state(dbg_state)
    );

    assign outs = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, pc_src, pc_write, beq, bne, illegal_op, mem_err};

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [5:0] rand_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rand_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_cycle(input logic [18:0] v, input logic rdy, input logic [5:0] op);
        exp_q.push_back(v);
        rdy_q.push_back(rdy);
        op_q.push_back(op);
    endtask

    // A memory wait of w idle cycles: completes with ready on cycle w+1 if w < T, else
    // times out after T cycles with mem_err on the last one.
    task automatic mem_phase(input logic [18:0] base, input logic [18:0] done_extra,
                             input int w, input bit fetch, input logic [5:0] op,
                             output bit ok);
        if (w >= T) begin
            for (int i = 0; i < T - 1; i++) push_cycle(base, 1'b0, fetch ? rand_op() : op);
            push_cycle(base | M_MEM_ERR, 1'b0, fetch ? rand_op() : op);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) push_cycle(base, 1'b0, fetch ? rand_op() : op);
            push_cycle(base | done_extra, 1'b1, fetch ? rand_op() : op);
            ok = 1'b1;
        end
    endtask

    task automatic model_fetch(input int fw);
        bit ok;
        int w;
        w = fw;
        ok = 1'b0;
        while (!ok) begin
            mem_phase(M_MEM_READ | M_SRCB_4, M_IR_WRITE | M_PC_WRITE, w, 1'b1, 6'h00, ok);
            w = 0;
        end
    endtask

    task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
        bit ok;
        bit legal;
        model_fetch(fw);
        legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
                (op == 6'h05) || (op == 6'h08) || (JUMP_EN && op == 6'h02);
        push_cycle(M_SRCB_SH | (legal ? 19'h0 : M_ILLEGAL), rand_bit(), op);
        if (!legal) return;
        case (op)
            6'h00: begin
                push_cycle(M_SRC_A | M_OP_FUNCT, rand_bit(), op);
                push_cycle(M_REG_WRITE | M_REG_DST, rand_bit(), op);
            end
            6'h23: begin
                push_cycle(M_SRC_A | M_SRCB_IMM, rand_bit(), op);
                mem_phase(M_IORD | M_MEM_READ, 19'h0, mw, 1'b0, op, ok);
                if (ok) push_cycle(M_REG_WRITE | M_MEM_TO_RG, rand_bit(), op);
            end
            6'h2B: begin
                push_cycle(M_SRC_A | M_SRCB_IMM, rand_bit(), op);
                mem_phase(M_IORD | M_MEM_WRITE, 19'h0, mw, 1'b0, op, ok);
            end
            6'h08: begin
                push_cycle(M_SRC_A | M_SRCB_IMM, rand_bit(), op);
                push_cycle(M_REG_WRITE, rand_bit(), op);
            end
            6'h04: push_cycle(M_SRC_A | M_OP_SUB | M_PC_ALUOUT | M_BEQ, rand_bit(), op);
            6'h05: push_cycle(M_SRC_A | M_OP_SUB | M_PC_ALUOUT | M_BNE, rand_bit(), op);
            default: push_cycle(M_PC_WRITE | M_PC_JUMP, rand_bit(), op);
        endcase
    endtask

    // ---------------- driver ----------------
    // Plays the queued inputs one per cycle, sampling outputs 1 time unit after the falling edge.
    task automatic run_cycles();
        while (rdy_q.size() > 0) begin
            @(negedge clk);
            opcode    = op_q.pop_front();
            mem_ready = rdy_q.pop_front();
            #1;
            got_q.push_back(outs);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode    = rand_op();
            mem_ready = rand_bit();
            #1;
            checks++;
            if (outs !== 19'h0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %h want %h", i, outs, 19'h0);
            end
        end
        @(negedge clk);
        reset     = 1'b1;
        opcode    = rand_op();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", outs, 19'h0);
        end
    endtask

    task automatic test_seq(input string name);
        logic [18:0] g, e;
        int n;
        run_cycles();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h want %h", name, n, g, e);
            end
            n++;
        end
        got_q.delete();
    endtask

    task automatic test_lw();
        model_instr(6'h23, 0, 0);
        test_seq("lw");
    endtask

    task automatic test_branch();
        model_instr(6'h04, 0, 0);
        model_instr(6'h05, 0, 0);
        test_seq("branch");
    endtask

    task automatic test_sw_timeout();
        model_instr(6'h2B, 0, 100);
        model_instr(6'h2B, 0, T - 1);
        model_instr(6'h2B, 0, T - 2);
        model_instr(6'h23, 0, 40);
        model_instr(6'h23, 0, T - 1);
        test_seq("mem_timeout");
    endtask

    task automatic test_illegal();
        model_instr(6'h3F, 0, 0);
        model_instr(6'h02, 0, 0);
        model_instr(6'h00, 0, 0);
        model_instr(6'h08, 0, 0);
        test_seq("decode");
    endtask

    task automatic test_fetch_timeout();
        model_instr(6'h08, 20, 0);
        model_instr(6'h00, T - 1, 0);
        test_seq("fetch_timeout");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[8];
        logic [5:0] op;
        int fw, mw;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};
        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = rand_op();
            fw = ($urandom_range(0, 9) == 0) ? T + 3 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(0, 4));
            model_instr(op, fw, mw);
        end
        test_seq("back_to_back");
    endtask

    task automatic test_reset_mid();
        model_fetch(0);
        push_cycle(M_SRCB_SH, rand_bit(), 6'h23);
        push_cycle(M_SRC_A | M_SRCB_IMM, rand_bit(), 6'h23);
        push_cycle(M_IORD | M_MEM_READ, 1'b0, 6'h23);
        test_seq("abort_prefix");
        #2;
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL abort_async: got %h want %h", outs, 19'h0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = rand_bit();
            #1;
            checks++;
            if (outs !== 19'h0) begin
                errors++;
                $display("FAIL abort_hold cyc%0d: got %h want %h", i, outs, 19'h0);
            end
        end
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL abort_idle: got %h want %h", outs, 19'h0);
        end
        model_instr(6'h08, 0, 0);
        test_seq("abort_restart");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_branch();
        test_sw_timeout();
        test_illegal();
        test_fetch_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
